fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter and instruction-fetch stage that consumes the next-PC redirect produced by branch resolution in EX. Owns the PC register, issues fetches to the instruction cache through a request/ready handshake that tolerates multi-cycle misses, and fills the IF/ID pipeline register. It applies stalls, flushes on redirect, and stops fetching on HLT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode in instr[15:12] that halts fetch.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  EX resolved a taken branch or BR; flush and refetch.
- redirect_addr  in  16  target PC, already selected between Rs and PC+2+imm<<1.
- stall  in  1  hazard unit holds PC and IF/ID.
- imem_req  out  1  fetch request to I-cache.
- imem_addr  out  16  fetch address (always even).
- imem_ready  in  1  I-cache returns data this cycle; asserted same cycle on hit, later on miss.
- imem_data  in  16  instruction word, valid when imem_ready.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  16  fetched instruction.
- if_id_pcplus2  out  16  fetch address + 2, consumed by branch logic in ID/EX.
- halted  out  1  fetch stopped on HLT.

## Operation
- States: FETCH, MISS_WAIT, HALTED.
- FETCH: imem_req=1, imem_addr=pc. A transfer completes on imem_req && imem_ready.
- Transfer in FETCH with no stall and no redirect: IF/ID <= {1, imem_data, pc+2}; pc <= pc+2. If imem_data[15:12]==HALT_OPCODE, go HALTED (the HLT word is still written to IF/ID).
- No imem_ready in FETCH: go MISS_WAIT; IF/ID valid cleared (bubble) unless stall.
- MISS_WAIT: imem_req held 1, imem_addr held at pc until imem_ready; then behave as a FETCH transfer and return to FETCH.
- stall=1: pc and IF/ID hold. A transfer completing under stall is discarded and re-requested at the same pc.
- redirect_valid=1 (any state, overrides stall): pc <= redirect_addr; if_id_valid <= 0; a transfer completing this cycle is dropped. From HALTED, return to FETCH (HLT in a branch shadow).
- Redirect during MISS_WAIT: the outstanding miss cannot be cancelled. Latch redirect_addr into a pending register, keep imem_addr unchanged until imem_ready, discard that data, then fetch the pending address. A second redirect before completion overwrites the pending address.
- HALTED: imem_req=0, halted=1, pc frozen, if_id_valid drops to 0 after the HLT word leaves IF/ID (not stalled). Only redirect or reset exits.
- Arithmetic: pc+2 is 16-bit modulo; 16'hFFFE wraps to 16'h0000. redirect_addr[0] is ignored (forced 0).

## Timing
- Reset (asynchronous, immediate): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=16'h0000, if_id_pcplus2=16'h0000, halted=0, pending redirect cleared. imem_req is 1 from the first cycle after rst_n deasserts.
- Hit latency: address presented in cycle N, IF/ID valid in cycle N+1, next sequential address presented in N+1 (one instruction per cycle).
- Redirect at edge of cycle N: imem_addr=redirect_addr in N+1 (not in MISS_WAIT); first redirected instruction in IF/ID at N+2 on a hit.
- Miss of k cycles: k bubbles in IF/ID.
- Reset asserted mid-miss: state is discarded; the late imem_ready after reset is not treated as a completion unless a request is outstanding.

## Structure
- Shared package/header: RESET_PC, HALT_OPCODE, NOP word 16'h0000, and the FETCH/MISS_WAIT/HALTED encodings (2-bit).
- PC+2 computed by the existing CLA_16bit adder instance (sub=0). No other sub-modules; the FSM, PC, pending-redirect and IF/ID registers live in this module.

## Test plan
- Reset, with hits every cycle from imem_data sequence 0x1000,0x1001,0x1002 -> imem_addr 0x0000,0x0002,0x0004; if_id_pcplus2 0x0002,0x0004,0x0006; no bubbles.
- Miss at pc 0x0004 with imem_ready low for 3 cycles -> imem_addr held at 0x0004, 3 bubbles, then instr valid with pcplus2=0x0006.
- Redirect to 0x0040 while the hit at 0x0008 completes -> 0x0008 data dropped, if_id_valid=0 next cycle, imem_addr=0x0040, then pcplus2=0x0042.
- Redirect to 0x0080 during a 4-cycle miss at 0x0010 -> addr stays 0x0010 until ready, data discarded, next imem_addr=0x0080.
- Fetch 0xF000 at 0x0020 -> halted=1 next cycle, imem_req=0; a later redirect to 0x0030 clears halted, fetches 0x0030. Simultaneous stall+redirect -> redirect wins.
- pc=0xFFFE hit -> next imem_addr=0x0000, if_id_pcplus2=0x0000. Assert rst_n low mid-miss -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and FSM encoding for the fetch/PC stage.
// Imported by the fetch FSM and its testbench.
package fetch_pc_unit_pkg;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_WORD    = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_MISS_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:12] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_cla.sv
// 16-bit carry-lookahead adder/subtractor.
// Built from four 4-bit lookahead groups with a second-level group carry chain.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    logic [15:0] bx;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  gg;
    logic [2:0]  gp;
    logic [3:0]  gc;

    assign bx = b ^ {16{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    for (genvar i = 0; i < 4; i++) begin : grp
        localparam int B = 4 * i;
        assign c[B]   = gc[i];
        assign c[B+1] = g[B] | (p[B] & gc[i]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[i]);
        // The top group's generate/propagate would only feed a carry-out.
        if (i < 3) begin : gsig
            assign gg[i] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[i] = &p[B+3:B];
        end
    end

    assign gc[0] = sub;
    assign gc[1] = gg[0] | (gp[0] & sub);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & sub);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & sub);

    assign sum = p ^ c;

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, I-cache fetch FSM and IF/ID pipeline register.
// Handles stalls, branch redirects (including during an uncancellable miss) and HLT.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_addr,
    input  logic         stall,
    output logic         imem_req,
    output logic [15:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [15:0]  imem_data,
    output logic         if_id_valid,
    output logic [15:0]  if_id_instr,
    output logic [15:0]  if_id_pcplus2,
    output logic         halted,
    output fetch_state_e fsm_state
);

    fetch_state_e state, state_n;
    logic [15:0]  pc, pc_n;
    logic         pend_valid, pend_valid_n;
    logic [15:0]  pend_addr, pend_addr_n;
    logic         ifv_n;
    logic [15:0]  instr_n;
    logic [15:0]  pcp2_n;
    logic [15:0]  pc_plus2;
    logic [15:0]  redir_even;
    logic         xfer;
    logic         take;

    CLA_16bit u_pc_add (
        .a   (pc),
        .b   (16'h0002),
        .sub (1'b0),
        .sum (pc_plus2)
    );

    // Handshake: a fetch transfer completes in any cycle where imem_req and
    // imem_ready are both high; imem_addr stays stable while imem_req waits.
    assign imem_req   = rst_n && (state != ST_HALTED);
    assign imem_addr  = pc;
    assign xfer       = imem_req && imem_ready;
    assign halted     = (state == ST_HALTED);
    assign fsm_state  = state;
    assign redir_even = redirect_addr & 16'hFFFE;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_valid_n = pend_valid;
        pend_addr_n  = pend_addr;
        ifv_n        = if_id_valid;
        instr_n      = if_id_instr;
        pcp2_n       = if_id_pcplus2;
        take         = 1'b0;

        case (state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_n  = redir_even;
                    ifv_n = 1'b0;
                end else if (xfer) begin
                    take = !stall;
                end else begin
                    state_n = ST_MISS_WAIT;
                    if (!stall) ifv_n = 1'b0;
                end
            end
            ST_MISS_WAIT: begin
                if (xfer) begin
                    state_n      = ST_FETCH;
                    pend_valid_n = 1'b0;
                    if (redirect_valid) begin
                        pc_n  = redir_even;
                        ifv_n = 1'b0;
                    end else if (pend_valid) begin
                        // Data for the stale address is dropped; refetch the branch target.
                        pc_n = pend_addr;
                        if (!stall) ifv_n = 1'b0;
                    end else begin
                        take = !stall;
                    end
                end else if (redirect_valid) begin
                    pend_valid_n = 1'b1;
                    pend_addr_n  = redir_even;
                    ifv_n        = 1'b0;
                end else if (!stall) begin
                    ifv_n = 1'b0;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    state_n = ST_FETCH;
                    pc_n    = redir_even;
                    ifv_n   = 1'b0;
                end else if (!stall) begin
                    ifv_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_FETCH;
            end
        endcase

        if (take) begin
            ifv_n   = 1'b1;
            instr_n = imem_data;
            pcp2_n  = pc_plus2;
            pc_n    = pc_plus2;
            state_n = is_halt(imem_data) ? ST_HALTED : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            pend_valid    <= 1'b0;
            pend_addr     <= 16'h0000;
            if_id_valid   <= 1'b0;
            if_id_instr   <= NOP_WORD;
            if_id_pcplus2 <= 16'h0000;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            pend_valid    <= pend_valid_n;
            pend_addr     <= pend_addr_n;
            if_id_valid   <= ifv_n;
            if_id_instr   <= instr_n;
            if_id_pcplus2 <= pcp2_n;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit: each row gives this cycle's
// inputs and the outputs expected before the clock edge that consumes them.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         redirect_valid;
    logic [15:0]  redirect_addr;
    logic         stall;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_ready;
    logic [15:0]  imem_data;
    logic         if_id_valid;
    logic [15:0]  if_id_instr;
    logic [15:0]  if_id_pcplus2;
    logic         halted;
    fetch_state_e fsm_state;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pcplus2  (if_id_pcplus2),
        .halted         (halted),
        .fsm_state      (fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rv;
        logic [15:0] ra;
        logic        st;
        logic        rdy;
        logic [15:0] data;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_ifv;
        logic [15:0] e_instr;
        logic [15:0] e_pcp2;
        logic        e_halt;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [15:0] ra, input logic st,
                         input logic rdy, input logic [15:0] data);
        redirect_valid = rv;
        redirect_addr  = ra;
        stall          = st;
        imem_ready     = rdy;
        imem_data      = data;
    endtask

    task automatic check_outputs(input string tag, input logic req, input logic [15:0] addr,
                                 input logic ifv, input logic [15:0] instr,
                                 input logic [15:0] pcp2, input logic hlt, input logic [1:0] stv);
        check({tag, ".imem_req"},      {15'd0, imem_req},      {15'd0, req});
        check({tag, ".imem_addr"},     imem_addr,              addr);
        check({tag, ".if_id_valid"},   {15'd0, if_id_valid},   {15'd0, ifv});
        check({tag, ".if_id_instr"},   if_id_instr,            instr);
        check({tag, ".if_id_pcplus2"}, if_id_pcplus2,          pcp2);
        check({tag, ".halted"},        {15'd0, halted},        {15'd0, hlt});
        check({tag, ".fsm_state"},     {14'd0, fsm_state},     {14'd0, stv});
    endtask

    task automatic add(input logic rv, input logic [15:0] ra, input logic st, input logic rdy,
                       input logic [15:0] data, input logic e_req, input logic [15:0] e_addr,
                       input logic e_ifv, input logic [15:0] e_instr, input logic [15:0] e_pcp2,
                       input logic e_halt, input logic [1:0] e_state);
        vec_t v;
        v = '{rv, ra, st, rdy, data, e_req, e_addr, e_ifv, e_instr, e_pcp2, e_halt, e_state};
        vecs.push_back(v);
    endtask

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] M = 2'd1;
    localparam logic [1:0] H = 2'd2;

    initial begin
        //   rv  ra        st  rdy data     | req addr     ifv instr    pcp2     hlt st
        // sequential hits, then a 3-cycle miss at 0x0004
        add(0, 16'h0000, 0, 1, 16'h1000,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0, F);
        add(0, 16'h0000, 0, 1, 16'h1001,   1, 16'h0002, 1, 16'h1000, 16'h0002, 0, F);
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0004, 1, 16'h1001, 16'h0004, 0, F);
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0004, 0, 16'h1001, 16'h0004, 0, M);
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0004, 0, 16'h1001, 16'h0004, 0, M);
        add(0, 16'h0000, 0, 1, 16'h1002,   1, 16'h0004, 0, 16'h1001, 16'h0004, 0, M);
        add(0, 16'h0000, 0, 1, 16'h1003,   1, 16'h0006, 1, 16'h1002, 16'h0006, 0, F);
        // redirect (odd target, bit 0 ignored) while the hit at 0x0008 completes
        add(1, 16'h0041, 0, 1, 16'h1004,   1, 16'h0008, 1, 16'h1003, 16'h0008, 0, F);
        add(0, 16'h0000, 0, 1, 16'h2000,   1, 16'h0040, 0, 16'h1003, 16'h0008, 0, F);
        // stall discards a completed transfer; same pc re-requested
        add(0, 16'h0000, 1, 1, 16'h2001,   1, 16'h0042, 1, 16'h2000, 16'h0042, 0, F);
        add(1, 16'h0010, 0, 0, 16'h0000,   1, 16'h0042, 1, 16'h2000, 16'h0042, 0, F);
        // 4-cycle miss at 0x0010 with two redirects; the later one wins
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0010, 0, 16'h2000, 16'h0042, 0, F);
        add(1, 16'h0070, 0, 0, 16'h0000,   1, 16'h0010, 0, 16'h2000, 16'h0042, 0, M);
        add(1, 16'h0080, 0, 0, 16'h0000,   1, 16'h0010, 0, 16'h2000, 16'h0042, 0, M);
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0010, 0, 16'h2000, 16'h0042, 0, M);
        add(0, 16'h0000, 0, 1, 16'hDEAD,   1, 16'h0010, 0, 16'h2000, 16'h0042, 0, M);
        add(1, 16'h0020, 0, 1, 16'h3001,   1, 16'h0080, 0, 16'h2000, 16'h0042, 0, F);
        // HLT at 0x0020
        add(0, 16'h0000, 0, 1, 16'hF000,   1, 16'h0020, 0, 16'h2000, 16'h0042, 0, F);
        add(0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0022, 1, 16'hF000, 16'h0022, 1, H);
        add(0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0022, 1, 16'hF000, 16'h0022, 1, H);
        // stall + redirect together: redirect wins and leaves HALTED
        add(1, 16'h0030, 1, 0, 16'h0000,   0, 16'h0022, 0, 16'hF000, 16'h0022, 1, H);
        add(0, 16'h0000, 0, 1, 16'h4000,   1, 16'h0030, 0, 16'hF000, 16'h0022, 0, F);
        // wrap at 0xFFFE
        add(1, 16'hFFFE, 0, 0, 16'h0000,   1, 16'h0032, 1, 16'h4000, 16'h0032, 0, F);
        add(0, 16'h0000, 0, 1, 16'h5000,   1, 16'hFFFE, 0, 16'h4000, 16'h0032, 0, F);
        add(0, 16'h0000, 0, 1, 16'h5001,   1, 16'h0000, 1, 16'h5000, 16'h0000, 0, F);
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0002, 1, 16'h5001, 16'h0002, 0, F);
        add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0002, 0, 16'h5001, 16'h0002, 0, M);

        rst_n = 1'b0;
        drive(0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check_outputs("reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, F);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].rv, vecs[i].ra, vecs[i].st, vecs[i].rdy, vecs[i].data);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ifv,
                          vecs[i].e_instr, vecs[i].e_pcp2, vecs[i].e_halt, vecs[i].e_state);
        end

        // reset asserted mid-miss: outputs return to reset values at once
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("midmiss_rst", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, F);

        // late ready while in reset must not complete anything
        drive(0, 16'h0000, 0, 1, 16'h7777);
        @(negedge clk);
        #1;
        check_outputs("in_rst_ready", 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, F);

        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 16'h0000, 0, 1, 16'h6000);
        #1;
        check_outputs("post_rst", 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, F);
        @(negedge clk);
        drive(0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check_outputs("post_rst_hit", 1, 16'h0002, 1, 16'h6000, 16'h0002, 0, F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
